// File: rtl/battleship_pkg.sv
// Shared types and constants for the Battleship game sequencer.
package battleship_pkg;

  typedef enum logic [3:0] {
    IDLE         = 4'd0,
    PLACE_PLAYER = 4'd1,
    PLACE_PC     = 4'd2,
    PLAYER_TURN  = 4'd3,
    WAIT_RES_P   = 4'd4,
    PC_TURN      = 4'd5,
    WAIT_RES_PC  = 4'd6,
    WIN          = 4'd7,
    LOSE         = 4'd8
  } estado_t;

  localparam logic [2:0] MAX_BARCOS = 3'd5;
  localparam logic [2:0] MIN_BARCOS = 3'd1;

  // True when a confirmed ship count is one the game can be played with.
  function automatic logic cantidad_valida(input logic [2:0] n);
    return (n >= MIN_BARCOS) && (n <= MAX_BARCOS);
  endfunction

endpackage

// File: rtl/turn_timer.sv
// Player turn down-counter: loaded with the full turn length, counts down
// while enabled and flags the last cycle of the turn.
module turn_timer #(
  parameter int TURN_CYCLES = 750000000,
  parameter int TCW         = $clog2(TURN_CYCLES + 1)
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           load,
  input  logic           enable,
  output logic [TCW-1:0] tiempo_restante,
  output logic           expire
);

  localparam logic [TCW-1:0] LOAD_VALUE = TCW'(TURN_CYCLES);
  localparam logic [TCW-1:0] ONE        = TCW'(1);

  logic [TCW-1:0] r_count;

  // Load takes priority; otherwise count down while enabled, stopping at 0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count <= '0;
    end else if (load) begin
      r_count <= LOAD_VALUE;
    end else if (enable && (r_count != '0)) begin
      r_count <= r_count - ONE;
    end
  end

  assign tiempo_restante = r_count;
  assign expire          = enable && (r_count == ONE);

endmodule

// File: rtl/battleship_turn_controller.sv
// Battleship game sequencer: ship-count latch, player/PC placement,
// alternating firing turns with a player timeout, and win/lose detection.
module battleship_turn_controller
  import battleship_pkg::*;
#(
  parameter int TURN_CYCLES = 750000000,
  parameter int TCW         = $clog2(TURN_CYCLES + 1)
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           seleccion_listo,
  input  logic [2:0]     cantidad_barcos,
  input  logic           colocar_valido,
  input  logic           pc_colocacion_lista,
  input  logic           disparo_jugador,
  input  logic           disparo_pc,
  input  logic           resultado_valido,
  input  logic           impacto,
  input  logic           hundido,
  output logic [3:0]     estado,
  output logic           habilitar_colocacion,
  output logic           iniciar_pc_colocacion,
  output logic           turno_jugador,
  output logic           solicitar_disparo_pc,
  output logic [2:0]     barcos_por_colocar,
  output logic [2:0]     barcos_jugador,
  output logic [2:0]     barcos_pc,
  output logic [TCW-1:0] tiempo_restante,
  output logic           timeout_turno,
  output logic           gano,
  output logic           perdio
);

  estado_t    r_state, w_state_next;
  logic [2:0] r_por_colocar, w_por_colocar_next;
  logic [2:0] r_barcos_jug, w_barcos_jug_next;
  logic [2:0] r_barcos_pc, w_barcos_pc_next;
  logic [2:0] w_jug_dec, w_pc_dec;
  logic       w_timeout_next;
  logic       w_timer_load, w_timer_en, w_expire;
  logic       r_habilitar, r_iniciar, r_turno, r_solicitar, r_timeout, r_gano, r_perdio;
  logic       w_unused;

  // Hit without sink changes nothing here; it only matters to the display.
  assign w_unused = impacto;

  // Saturating sink decrements.
  assign w_jug_dec = (r_barcos_jug == 3'd0) ? 3'd0 : r_barcos_jug - 3'd1;
  assign w_pc_dec  = (r_barcos_pc == 3'd0) ? 3'd0 : r_barcos_pc - 3'd1;

  // The timer runs only while the player holds the turn and reloads on entry.
  assign w_timer_en   = (r_state == PLAYER_TURN);
  assign w_timer_load = (w_state_next == PLAYER_TURN) && (r_state != PLAYER_TURN);

  turn_timer #(
    .TURN_CYCLES (TURN_CYCLES),
    .TCW         (TCW)
  ) u_turn_timer (
    .clk             (clk),
    .reset           (reset),
    .load            (w_timer_load),
    .enable          (w_timer_en),
    .tiempo_restante (tiempo_restante),
    .expire          (w_expire)
  );

  // Next-state and counter updates; only the inputs relevant to a state are looked at.
  always_comb begin
    w_state_next       = r_state;
    w_por_colocar_next = r_por_colocar;
    w_barcos_jug_next  = r_barcos_jug;
    w_barcos_pc_next   = r_barcos_pc;
    w_timeout_next     = 1'b0;
    case (r_state)
      IDLE: begin
        if (seleccion_listo && cantidad_valida(cantidad_barcos)) begin
          w_state_next       = PLACE_PLAYER;
          w_por_colocar_next = cantidad_barcos;
          w_barcos_jug_next  = cantidad_barcos;
          w_barcos_pc_next   = cantidad_barcos;
        end
      end
      PLACE_PLAYER: begin
        if (colocar_valido) begin
          w_por_colocar_next = r_por_colocar - 3'd1;
          if (r_por_colocar == 3'd1) begin
            w_state_next = PLACE_PC;
          end
        end
      end
      PLACE_PC: begin
        if (pc_colocacion_lista) begin
          w_state_next = PLAYER_TURN;
        end
      end
      PLAYER_TURN: begin
        // A shot in the expiry cycle still counts as a shot.
        if (disparo_jugador) begin
          w_state_next = WAIT_RES_P;
        end else if (w_expire) begin
          w_state_next   = PC_TURN;
          w_timeout_next = 1'b1;
        end
      end
      WAIT_RES_P: begin
        if (resultado_valido) begin
          if (hundido) begin
            w_barcos_pc_next = w_pc_dec;
          end
          w_state_next = ((hundido ? w_pc_dec : r_barcos_pc) == 3'd0) ? WIN : PC_TURN;
        end
      end
      PC_TURN: begin
        if (disparo_pc) begin
          w_state_next = WAIT_RES_PC;
        end
      end
      WAIT_RES_PC: begin
        if (resultado_valido) begin
          if (hundido) begin
            w_barcos_jug_next = w_jug_dec;
          end
          w_state_next = ((hundido ? w_jug_dec : r_barcos_jug) == 3'd0) ? LOSE : PLAYER_TURN;
        end
      end
      default: begin
        w_state_next = r_state;
      end
    endcase
  end

  // State and ship counters.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= IDLE;
      r_por_colocar <= 3'd0;
      r_barcos_jug  <= 3'd0;
      r_barcos_pc   <= 3'd0;
    end else begin
      r_state       <= w_state_next;
      r_por_colocar <= w_por_colocar_next;
      r_barcos_jug  <= w_barcos_jug_next;
      r_barcos_pc   <= w_barcos_pc_next;
    end
  end

  // Registered flags, computed from the upcoming state so they align with it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_habilitar <= 1'b0;
      r_iniciar   <= 1'b0;
      r_turno     <= 1'b0;
      r_solicitar <= 1'b0;
      r_timeout   <= 1'b0;
      r_gano      <= 1'b0;
      r_perdio    <= 1'b0;
    end else begin
      r_habilitar <= (w_state_next == PLACE_PLAYER);
      r_iniciar   <= (w_state_next == PLACE_PC) && (r_state == PLACE_PLAYER);
      r_turno     <= (w_state_next == PLAYER_TURN) || (w_state_next == WAIT_RES_P);
      r_solicitar <= (w_state_next == PC_TURN) && (r_state != PC_TURN);
      r_timeout   <= w_timeout_next;
      r_gano      <= (w_state_next == WIN);
      r_perdio    <= (w_state_next == LOSE);
    end
  end

  assign estado                = r_state;
  assign habilitar_colocacion  = r_habilitar;
  assign iniciar_pc_colocacion = r_iniciar;
  assign turno_jugador         = r_turno;
  assign solicitar_disparo_pc  = r_solicitar;
  assign barcos_por_colocar    = r_por_colocar;
  assign barcos_jugador        = r_barcos_jug;
  assign barcos_pc             = r_barcos_pc;
  assign timeout_turno         = r_timeout;
  assign gano                  = r_gano;
  assign perdio                = r_perdio;

endmodule

// File: tb/tb_battleship_turn_controller.sv
// Scenario bench for the Battleship turn controller with a short turn length.
module tb_battleship_turn_controller;
  import battleship_pkg::*;

  localparam int TC  = 4;
  localparam int TCW = $clog2(TC + 1);

  logic           clk = 1'b0;
  logic           reset;
  logic           seleccion_listo, colocar_valido, pc_colocacion_lista;
  logic           disparo_jugador, disparo_pc, resultado_valido, impacto, hundido;
  logic [2:0]     cantidad_barcos;
  logic [3:0]     estado;
  logic           habilitar_colocacion, iniciar_pc_colocacion, turno_jugador;
  logic           solicitar_disparo_pc, timeout_turno, gano, perdio;
  logic [2:0]     barcos_por_colocar, barcos_jugador, barcos_pc;
  logic [TCW-1:0] tiempo_restante;

  int n_checks = 0;
  int n_fail   = 0;

  battleship_turn_controller #(.TURN_CYCLES(TC), .TCW(TCW)) dut (
    .clk                   (clk),
    .reset                 (reset),
    .seleccion_listo       (seleccion_listo),
    .cantidad_barcos       (cantidad_barcos),
    .colocar_valido        (colocar_valido),
    .pc_colocacion_lista   (pc_colocacion_lista),
    .disparo_jugador       (disparo_jugador),
    .disparo_pc            (disparo_pc),
    .resultado_valido      (resultado_valido),
    .impacto               (impacto),
    .hundido               (hundido),
    .estado                (estado),
    .habilitar_colocacion  (habilitar_colocacion),
    .iniciar_pc_colocacion (iniciar_pc_colocacion),
    .turno_jugador         (turno_jugador),
    .solicitar_disparo_pc  (solicitar_disparo_pc),
    .barcos_por_colocar    (barcos_por_colocar),
    .barcos_jugador        (barcos_jugador),
    .barcos_pc             (barcos_pc),
    .tiempo_restante       (tiempo_restante),
    .timeout_turno         (timeout_turno),
    .gano                  (gano),
    .perdio                (perdio)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    seleccion_listo = 0; cantidad_barcos = 0; colocar_valido = 0; pc_colocacion_lista = 0;
    disparo_jugador = 0; disparo_pc = 0; resultado_valido = 0; impacto = 0; hundido = 0;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset = 1;
    tick();
    tick();
    reset = 0;
  endtask

  // Drive a full selection and placement sequence for n ships.
  task automatic go_to_turn(input int n);
    seleccion_listo = 1; cantidad_barcos = 3'(n);
    tick();
    seleccion_listo = 0;
    for (int i = 0; i < n; i++) begin
      colocar_valido = 1; tick(); colocar_valido = 0; tick();
    end
    pc_colocacion_lista = 1; tick(); pc_colocacion_lista = 0;
  endtask

  task automatic test_reset();
    logic [31:0] all_out;
    reset = 1; clear_inputs();
    #1;
    tick();
    all_out = {estado, habilitar_colocacion, iniciar_pc_colocacion, turno_jugador, solicitar_disparo_pc,
               barcos_por_colocar, barcos_jugador, barcos_pc, tiempo_restante, timeout_turno, gano, perdio};
    n_checks++;
    if (all_out !== 32'd0) begin n_fail++; $display("FAIL reset_outputs: got %h expected 0", all_out); end
    reset = 0;
    tick();
    n_checks++;
    if (estado !== 4'(IDLE)) begin n_fail++; $display("FAIL reset_idle: got %0d expected %0d", estado, IDLE); end
    $display("txn reset: estado=%0d", estado);
  endtask

  task automatic test_placement();
    int pulses = 0;
    do_reset();
    seleccion_listo = 1; cantidad_barcos = 3'd3;
    tick();
    seleccion_listo = 0;
    n_checks++;
    if (estado !== 4'(PLACE_PLAYER) || barcos_por_colocar !== 3'd3 || habilitar_colocacion !== 1'b1)
      begin n_fail++; $display("FAIL place_enter: estado=%0d left=%0d hab=%0d expected 1/3/1", estado, barcos_por_colocar, habilitar_colocacion); end
    for (int i = 0; i < 3; i++) begin
      colocar_valido = 1; tick(); colocar_valido = 0;
      pulses += int'(iniciar_pc_colocacion);
      n_checks++;
      if (barcos_por_colocar !== 3'(2 - i)) begin n_fail++; $display("FAIL place_count: got %0d expected %0d", barcos_por_colocar, 2 - i); end
      $display("txn place ship %0d: left=%0d", i, barcos_por_colocar);
      tick();
      pulses += int'(iniciar_pc_colocacion);
    end
    n_checks++;
    if (estado !== 4'(PLACE_PC) || habilitar_colocacion !== 1'b0) begin n_fail++; $display("FAIL place_pc_state: got %0d expected %0d", estado, PLACE_PC); end
    // Firing inputs are meaningless during PC placement.
    disparo_jugador = 1; resultado_valido = 1; hundido = 1; tick(); clear_inputs();
    for (int i = 0; i < 3; i++) begin tick(); pulses += int'(iniciar_pc_colocacion); end
    n_checks++;
    if (pulses !== 1) begin n_fail++; $display("FAIL iniciar_pulse_count: got %0d expected 1", pulses); end
    n_checks++;
    if (estado !== 4'(PLACE_PC)) begin n_fail++; $display("FAIL place_pc_ignore: got %0d expected %0d", estado, PLACE_PC); end
    pc_colocacion_lista = 1; tick(); pc_colocacion_lista = 0;
    n_checks++;
    if (estado !== 4'(PLAYER_TURN) || barcos_jugador !== 3'd3 || barcos_pc !== 3'd3 ||
        turno_jugador !== 1'b1 || tiempo_restante !== TCW'(TC))
      begin n_fail++; $display("FAIL turn_enter: estado=%0d jug=%0d pc=%0d turno=%0d t=%0d expected 3/3/3/1/%0d",
                               estado, barcos_jugador, barcos_pc, turno_jugador, tiempo_restante, TC); end
    $display("txn pc placement done: estado=%0d", estado);
  endtask

  task automatic test_invalid_count();
    logic [2:0] bad [3];
    bad[0] = 3'd6; bad[1] = 3'd0; bad[2] = 3'd7;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      seleccion_listo = 1; cantidad_barcos = bad[i]; tick();
      n_checks++;
      if (estado !== 4'(IDLE) || barcos_pc !== 3'd0) begin n_fail++; $display("FAIL bad_count_%0d: estado=%0d expected %0d", bad[i], estado, IDLE); end
      $display("txn select count %0d: estado=%0d", bad[i], estado);
    end
    cantidad_barcos = 3'd2; tick(); seleccion_listo = 0;
    n_checks++;
    if (estado !== 4'(PLACE_PLAYER) || barcos_por_colocar !== 3'd2 || barcos_jugador !== 3'd2)
      begin n_fail++; $display("FAIL good_count: estado=%0d left=%0d expected 1/2", estado, barcos_por_colocar); end
    // A late, different selection must not be taken after IDLE.
    seleccion_listo = 1; cantidad_barcos = 3'd5; tick(); seleccion_listo = 0;
    n_checks++;
    if (barcos_por_colocar !== 3'd2) begin n_fail++; $display("FAIL select_after_idle: got %0d expected 2", barcos_por_colocar); end
  endtask

  task automatic test_timeout();
    do_reset();
    go_to_turn(1);
    for (int k = 1; k < TC; k++) begin
      tick();
      n_checks++;
      if (estado !== 4'(PLAYER_TURN) || tiempo_restante !== TCW'(TC - k) || timeout_turno !== 1'b0)
        begin n_fail++; $display("FAIL timer_count: estado=%0d t=%0d to=%0d expected t=%0d", estado, tiempo_restante, timeout_turno, TC - k); end
    end
    tick();
    n_checks++;
    if (estado !== 4'(PC_TURN) || timeout_turno !== 1'b1 || tiempo_restante !== '0 ||
        solicitar_disparo_pc !== 1'b1 || turno_jugador !== 1'b0)
      begin n_fail++; $display("FAIL timeout_fire: estado=%0d to=%0d t=%0d sol=%0d expected %0d/1/0/1", estado, timeout_turno, tiempo_restante, solicitar_disparo_pc, PC_TURN); end
    tick();
    n_checks++;
    if (timeout_turno !== 1'b0 || solicitar_disparo_pc !== 1'b0)
      begin n_fail++; $display("FAIL timeout_single: to=%0d sol=%0d expected 0/0", timeout_turno, solicitar_disparo_pc); end
    $display("txn timeout: estado=%0d", estado);
  endtask

  task automatic test_shot_at_expiry();
    do_reset();
    go_to_turn(2);
    repeat (TC - 1) tick();
    disparo_jugador = 1; tick(); disparo_jugador = 0;
    n_checks++;
    if (estado !== 4'(WAIT_RES_P) || timeout_turno !== 1'b0 || turno_jugador !== 1'b1)
      begin n_fail++; $display("FAIL shot_expiry: estado=%0d to=%0d expected %0d/0", estado, timeout_turno, WAIT_RES_P); end
    repeat (TC + 2) tick();
    n_checks++;
    if (estado !== 4'(WAIT_RES_P) || timeout_turno !== 1'b0 || tiempo_restante !== '0)
      begin n_fail++; $display("FAIL wait_frozen: estado=%0d to=%0d t=%0d expected %0d/0/0", estado, timeout_turno, tiempo_restante, WAIT_RES_P); end
    $display("txn shot at expiry: estado=%0d", estado);
  endtask

  task automatic test_win();
    do_reset();
    go_to_turn(1);
    tick();
    disparo_jugador = 1; tick(); disparo_jugador = 0;
    n_checks++;
    if (tiempo_restante !== TCW'(TC - 2)) begin n_fail++; $display("FAIL shot_timer: got %0d expected %0d", tiempo_restante, TC - 2); end
    resultado_valido = 1; impacto = 1; hundido = 1; tick(); clear_inputs();
    n_checks++;
    if (estado !== 4'(WIN) || gano !== 1'b1 || barcos_pc !== 3'd0 || perdio !== 1'b0)
      begin n_fail++; $display("FAIL win: estado=%0d gano=%0d pc=%0d expected %0d/1/0", estado, gano, barcos_pc, WIN); end
    for (int i = 0; i < 12; i++) begin
      seleccion_listo = 1'($urandom); cantidad_barcos = 3'($urandom);
      disparo_pc = (i % 2 == 0); disparo_jugador = (i % 2 == 1);
      resultado_valido = (i % 2 == 0); hundido = 1; colocar_valido = (i % 2 == 1);
      tick();
    end
    clear_inputs();
    tick();
    n_checks++;
    if (estado !== 4'(WIN) || gano !== 1'b1 || barcos_pc !== 3'd0 || barcos_jugador !== 3'd1)
      begin n_fail++; $display("FAIL win_terminal: estado=%0d gano=%0d pc=%0d jug=%0d", estado, gano, barcos_pc, barcos_jugador); end
    $display("txn win: estado=%0d", estado);
  endtask

  task automatic test_lose_and_reset();
    logic [31:0] all_out;
    do_reset();
    go_to_turn(2);
    for (int r = 0; r < 2; r++) begin
      disparo_jugador = 1; tick(); disparo_jugador = 0;
      resultado_valido = 1; impacto = 1; hundido = 0; tick(); clear_inputs();
      disparo_pc = 1; tick(); disparo_pc = 0;
      resultado_valido = 1; impacto = (r == 0); hundido = 1; tick(); clear_inputs();
      n_checks++;
      if (barcos_jugador !== 3'(1 - r) || barcos_pc !== 3'd2)
        begin n_fail++; $display("FAIL pc_sink_%0d: jug=%0d pc=%0d expected %0d/2", r, barcos_jugador, barcos_pc, 1 - r); end
      $display("txn round %0d: estado=%0d jug=%0d", r, estado, barcos_jugador);
    end
    n_checks++;
    if (estado !== 4'(LOSE) || perdio !== 1'b1 || gano !== 1'b0)
      begin n_fail++; $display("FAIL lose: estado=%0d perdio=%0d expected %0d/1", estado, perdio, LOSE); end
    do_reset();
    go_to_turn(2);
    disparo_jugador = 1; tick(); disparo_jugador = 0;
    resultado_valido = 1; hundido = 1;
    #2;
    reset = 1;
    #1;
    all_out = {estado, habilitar_colocacion, iniciar_pc_colocacion, turno_jugador, solicitar_disparo_pc,
               barcos_por_colocar, barcos_jugador, barcos_pc, tiempo_restante, timeout_turno, gano, perdio};
    n_checks++;
    if (all_out !== 32'd0) begin n_fail++; $display("FAIL async_reset: got %h expected 0", all_out); end
    tick();
    clear_inputs();
    reset = 0;
    tick();
    n_checks++;
    if (estado !== 4'(IDLE)) begin n_fail++; $display("FAIL reset_hold_idle: got %0d expected %0d", estado, IDLE); end
    $display("txn reset mid game: estado=%0d", estado);
  endtask

  // Random full games scored against a turn-by-turn model of the rules.
  task automatic test_random_games(input int games);
    int n, m_jug, m_pc, turns, d, ok;
    logic s;
    estado_t exp_st;
    for (int g = 0; g < games; g++) begin
      do_reset();
      n = $urandom_range(1, 5);
      go_to_turn(n);
      m_jug = n; m_pc = n; turns = 0;
      n_checks++;
      if (estado !== 4'(PLAYER_TURN) || barcos_pc !== 3'(n)) begin n_fail++; $display("FAIL rg_start: estado=%0d pc=%0d expected %0d/%0d", estado, barcos_pc, PLAYER_TURN, n); end
      while (m_jug > 0 && m_pc > 0 && turns < 30) begin
        if ($urandom_range(0, 3) == 0) begin
          repeat (TC) tick();
          n_checks++;
          if (estado !== 4'(PC_TURN) || timeout_turno !== 1'b1) begin n_fail++; $display("FAIL rg_timeout: estado=%0d to=%0d expected %0d/1", estado, timeout_turno, PC_TURN); end
        end else begin
          d = $urandom_range(0, TC - 1);
          repeat (d) tick();
          n_checks++;
          if (tiempo_restante !== TCW'(TC - d)) begin n_fail++; $display("FAIL rg_timer: got %0d expected %0d", tiempo_restante, TC - d); end
          disparo_jugador = 1; tick(); disparo_jugador = 0;
          repeat ($urandom_range(0, 2)) tick();
          s = ($urandom_range(0, 2) == 0);
          resultado_valido = 1; hundido = s; impacto = s | 1'($urandom); tick(); clear_inputs();
          if (s) m_pc--;
          exp_st = (m_pc == 0) ? WIN : PC_TURN;
          n_checks++;
          if (estado !== 4'(exp_st) || barcos_pc !== 3'(m_pc)) begin n_fail++; $display("FAIL rg_player_res: estado=%0d pc=%0d expected %0d/%0d", estado, barcos_pc, exp_st, m_pc); end
        end
        if (m_pc > 0) begin
          n_checks++;
          if (solicitar_disparo_pc !== 1'b1) begin n_fail++; $display("FAIL rg_solicitar: got %0d expected 1", solicitar_disparo_pc); end
          repeat ($urandom_range(0, 2)) tick();
          disparo_pc = 1; tick(); disparo_pc = 0;
          repeat ($urandom_range(0, 2)) tick();
          s = ($urandom_range(0, 2) == 0);
          resultado_valido = 1; hundido = s; impacto = 1'($urandom); tick(); clear_inputs();
          if (s) m_jug--;
          exp_st = (m_jug == 0) ? LOSE : PLAYER_TURN;
          ok = (estado === 4'(exp_st)) && (barcos_jugador === 3'(m_jug)) &&
               (exp_st != PLAYER_TURN || tiempo_restante === TCW'(TC));
          n_checks++;
          if (ok == 0) begin n_fail++; $display("FAIL rg_pc_res: estado=%0d jug=%0d t=%0d expected %0d/%0d", estado, barcos_jugador, tiempo_restante, exp_st, m_jug); end
        end
        turns++;
      end
      n_checks++;
      if (gano !== 1'(m_pc == 0) || perdio !== 1'(m_jug == 0))
        begin n_fail++; $display("FAIL rg_outcome: gano=%0d perdio=%0d expected %0d/%0d", gano, perdio, m_pc == 0, m_jug == 0); end
      $display("txn game %0d: N=%0d turns=%0d jug=%0d pc=%0d estado=%0d", g, n, turns, m_jug, m_pc, estado);
    end
  endtask

  initial begin
    clear_inputs();
    reset = 1;
    test_reset();
    test_placement();
    test_invalid_count();
    test_timeout();
    test_shot_at_expiry();
    test_win();
    test_lose_and_reset();
    test_random_games(8);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
